// File: rtl/decode_if.sv
// Decode stage bus: fetch handshake, write-back port, flush, execute-side
// handshake with the registered decode result, and the debug register tap.
interface decode_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       ins;
  logic [DATA_W-1:0] npc_i;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        op;
  logic [5:0]        func;
  logic [25:0]       jpc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [REG_AW-1:0] dst_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] npc_o;
  logic [DATA_W-1:0] dbg_reg;

  // Fetch/write-back/execute environment side.
  modport master (
    output in_valid, ins, npc_i, wb_en, wb_reg, wb_data, flush, out_ready,
    input  in_ready, out_valid, op, func, jpc, imm, data_a, data_b, dst_reg,
           reg_write, mem_read, mem_write, npc_o, dbg_reg
  );

  // Decode stage side.
  modport slave (
    input  in_valid, ins, npc_i, wb_en, wb_reg, wb_data, flush, out_ready,
    output in_ready, out_valid, op, func, jpc, imm, data_a, data_b, dst_reg,
           reg_write, mem_read, mem_write, npc_o, dbg_reg
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register file with write-back bypass, instruction decode and
// a registered valid/ready output slot toward execute.
// Optional load-use interlock: define DECODE_LOAD_USE_STALL_EN.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DBG_IDX = 8
) (
  input logic   clk,
  input logic   rst_n,
  decode_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_BGTZ = 6'h07, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
    OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e, OP_LUI  = 6'h0f,
    OP_LB    = 6'h20, OP_LW   = 6'h23, OP_SB    = 6'h28, OP_SW   = 6'h2b
  } opcode_e;

  logic [DATA_W-1:0] regs [NREG];
  opcode_e           op_e;
  logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx;
  logic              wb_hit;
  logic              stall;
  logic              accept;
  logic              d_rw, d_mr, d_mw;
  logic [REG_AW-1:0] d_dst;
  logic [DATA_W-1:0] d_imm, d_a, d_b;

  assign op_e   = opcode_e'(bus.ins[31:26]);
  assign rs_idx = REG_AW'(bus.ins[25:21]);
  assign rt_idx = REG_AW'(bus.ins[20:16]);
  assign rd_idx = REG_AW'(bus.ins[15:11]);
  assign wb_hit = bus.wb_en && (bus.wb_reg != '0);

  // Operand read with same-cycle write-back forwarding; register 0 is never
  // written, so reading it always yields zero.
  assign d_a = (wb_hit && bus.wb_reg == rs_idx) ? bus.wb_data : regs[rs_idx];
  assign d_b = (wb_hit && bus.wb_reg == rt_idx) ? bus.wb_data : regs[rt_idx];

  // Logical immediates are zero-extended, everything else sign-extended.
  assign d_imm = (op_e == OP_ANDI || op_e == OP_ORI || op_e == OP_XORI)
               ? DATA_W'(bus.ins[15:0])
               : DATA_W'($signed(bus.ins[15:0]));

  assign bus.dbg_reg = regs[DBG_IDX];

`ifdef DECODE_LOAD_USE_STALL_EN
  logic uses_rt;
  // Only these opcodes actually consume rt as a source operand.
  assign uses_rt = (op_e == OP_RTYPE) || (op_e == OP_BEQ) || (op_e == OP_BNE) ||
                   (op_e == OP_SW)    || (op_e == OP_SB);
  // Hold a consumer back while the held instruction is a load to its source.
  assign stall = bus.out_valid && bus.mem_read && (bus.dst_reg != '0) &&
                 ((bus.dst_reg == rs_idx) || (bus.dst_reg == rt_idx && uses_rt));
`else
  assign stall = 1'b0;
`endif

  assign bus.in_ready = rst_n && !bus.flush && !stall &&
                        (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Control-bit decode per opcode class.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    d_rw  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_dst = '0;
    case (op_e)
      OP_RTYPE: begin d_rw = 1'b1; d_dst = rd_idx; end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d_rw = 1'b1; d_dst = rt_idx;
      end
      OP_LB, OP_LW: begin d_rw = 1'b1; d_mr = 1'b1; d_dst = rt_idx; end
      OP_SB, OP_SW: d_mw = 1'b1;
      OP_JAL:   begin d_rw = 1'b1; d_dst = '1; end
      default:  ;
    endcase
  end

  // Register file write-back; register 0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the whole array is reset because reset must clear every register;
    // this forces flops rather than a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      // NOTE: sequential state always uses non-blocking assignment.
      regs[bus.wb_reg] <= bus.wb_data;
    end
  end

  // Output slot: flush wins, then load on accept, then drain on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.op        <= '0;
      bus.func      <= '0;
      bus.jpc       <= '0;
      bus.imm       <= '0;
      bus.data_a    <= '0;
      bus.data_b    <= '0;
      bus.dst_reg   <= '0;
      bus.reg_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.npc_o     <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.op        <= bus.ins[31:26];
      bus.func      <= bus.ins[5:0];
      bus.jpc       <= bus.ins[25:0];
      bus.imm       <= d_imm;
      bus.data_a    <= d_a;
      bus.data_b    <= d_b;
      bus.dst_reg   <= d_dst;
      bus.reg_write <= d_rw;
      bus.mem_read  <= d_mr;
      bus.mem_write <= d_mw;
      bus.npc_o     <= bus.npc_i;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  decode_if #(.DATA_W(32), .REG_AW(5)) bus ();

  decode_stage #(.DATA_W(32), .REG_AW(5), .DBG_IDX(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [25:0] jpc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] npc;
  } res_t;

  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  res_t        m_out = '0;

  function automatic res_t model_decode(input logic [31:0] i, input logic [31:0] npc,
                                        input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [5:0] o;
    o = i[31:26];
    r = '0;
    r.op = o; r.func = i[5:0]; r.jpc = i[25:0]; r.npc = npc; r.a = a; r.b = b;
    if (o == 6'h0c || o == 6'h0d || o == 6'h0e) r.imm = {16'h0, i[15:0]};
    else r.imm = {{16{i[15]}}, i[15:0]};
    case (o)
      6'h00: begin r.rw = 1; r.dst = i[15:11]; end
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin r.rw = 1; r.dst = i[20:16]; end
      6'h20, 6'h23: begin r.rw = 1; r.mr = 1; r.dst = i[20:16]; end
      6'h28, 6'h2b: r.mw = 1;
      6'h03: begin r.rw = 1; r.dst = 5'd31; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic model_stall();
`ifdef DECODE_LOAD_USE_STALL_EN
    logic [5:0] o;
    logic [4:0] rs, rt;
    o = bus.ins[31:26]; rs = bus.ins[25:21]; rt = bus.ins[20:16];
    return m_valid && m_out.mr && m_out.dst != 0 &&
           (m_out.dst == rs ||
            (m_out.dst == rt && (o == 6'h00 || o == 6'h04 || o == 6'h05 ||
                                 o == 6'h2b || o == 6'h28)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_in_ready();
    return rst_n && !bus.flush && !model_stall() && (!m_valid || bus.out_ready);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (bus.wb_en && bus.wb_reg != 0 && bus.wb_reg == idx) return bus.wb_data;
    return (idx == 0) ? 32'h0 : m_regs[idx];
  endfunction

  // Model state advances on each clock edge from the inputs presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_out = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      if (bus.flush) m_valid = 1'b0;
      else if (bus.in_valid && model_in_ready()) begin
        m_out = model_decode(bus.ins, bus.npc_i, model_read(bus.ins[25:21]),
                             model_read(bus.ins[20:16]));
        m_valid = 1'b1;
      end else if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (bus.wb_en && bus.wb_reg != 0) m_regs[bus.wb_reg] = bus.wb_data;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  bus.in_ready,  model_in_ready());
      check("out_valid", bus.out_valid, m_valid);
      check("op",        bus.op,        m_out.op);
      check("func",      bus.func,      m_out.func);
      check("jpc",       bus.jpc,       m_out.jpc);
      check("imm",       bus.imm,       m_out.imm);
      check("data_a",    bus.data_a,    m_out.a);
      check("data_b",    bus.data_b,    m_out.b);
      check("dst_reg",   bus.dst_reg,   m_out.dst);
      check("reg_write", bus.reg_write, m_out.rw);
      check("mem_read",  bus.mem_read,  m_out.mr);
      check("mem_write", bus.mem_write, m_out.mw);
      check("npc_o",     bus.npc_o,     m_out.npc);
      check("dbg_reg",   bus.dbg_reg,   m_regs[8]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
                           6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h23, 6'h28, 6'h2b};

  task automatic randomize_inputs();
    logic [5:0] o;
    logic [4:0] rs, rt;
    int k;
    k  = $urandom_range(0, 16);
    o  = (k == 16) ? 6'($urandom) : ops[k];
    rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
    rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
    bus.ins       = {o, rs, rt, 16'($urandom)};
    bus.npc_i     = $urandom;
    bus.in_valid  = $urandom_range(0, 3) != 0;
    bus.out_ready = $urandom_range(0, 3) != 0;
    bus.flush     = $urandom_range(0, 15) == 0;
    bus.wb_en     = 1'($urandom_range(0, 1));
    bus.wb_reg    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
    bus.wb_data   = $urandom;
  endtask

  initial begin
    bus.in_valid = 0; bus.ins = 0; bus.npc_i = 0; bus.wb_en = 0; bus.wb_reg = 0;
    bus.wb_data = 0; bus.flush = 0; bus.out_ready = 0;

    // Reset state.
    step();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_dbg_reg",   bus.dbg_reg,   32'h0);
    step();
    rst_n = 1'b1;
    started = 1'b1;

    // Write-back to r8 with a same-cycle ADD reading rs=8 (bypass).
    bus.wb_en = 1; bus.wb_reg = 8; bus.wb_data = 32'h1234;
    bus.in_valid = 1; bus.out_ready = 1; bus.npc_i = 32'h100;
    bus.ins = {6'h00, 5'd8, 5'd0, 5'd9, 5'd0, 6'h20};
    step();
    bus.wb_en = 0;
    check("wr_rd_data_a",  bus.data_a,   32'h1234);
    check("wr_rd_dbg",     bus.dbg_reg,  32'h1234);
    check("wr_rd_dst",     bus.dst_reg,  5'd9);
    check("wr_rd_valid",   bus.out_valid, 1'b1);

    // ORI zero-extends, ADDI sign-extends the same immediate.
    bus.ins = {6'h0d, 5'd0, 5'd3, 16'h8001};
    step();
    check("ori_imm",       bus.imm,       32'h0000_8001);
    check("ori_reg_write", bus.reg_write, 1'b1);
    check("ori_dst",       bus.dst_reg,   5'd3);
    check("model_ori_imm", m_out.imm,     32'h0000_8001);
    bus.ins = {6'h08, 5'd0, 5'd3, 16'h8001};
    step();
    check("addi_imm",       bus.imm,  32'hFFFF_8001);
    check("model_addi_imm", m_out.imm, 32'hFFFF_8001);

    // Backpressure: three stalled cycles then release.
    bus.out_ready = 0;
    bus.ins = {6'h0e, 5'd0, 5'd4, 16'hF00F};
    #1;
    check("bp_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready_hold", bus.in_ready, 1'b0);
      check("bp_imm_hold",      bus.imm,      32'hFFFF_8001);
      check("bp_op_hold",       bus.op,       6'h08);
    end
    bus.out_ready = 1;
    step();
    check("bp_release_imm", bus.imm,     32'h0000_F00F);
    check("bp_release_op",  bus.op,      6'h0e);
    check("bp_release_dst", bus.dst_reg, 5'd4);

    // Load followed by a dependent ADD.
    bus.ins = {6'h23, 5'd0, 5'd5, 16'h0004};
    step();
    check("lw_mem_read", bus.mem_read, 1'b1);
    check("lw_dst",      bus.dst_reg,  5'd5);
    bus.ins = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20};
    #1;
`ifdef DECODE_LOAD_USE_STALL_EN
    check("lu_in_ready", bus.in_ready, 1'b0);
    step();
    check("lu_bubble",   bus.out_valid, 1'b0);
    step();
`else
    check("lu_in_ready", bus.in_ready, 1'b1);
    step();
`endif
    check("lu_add_valid", bus.out_valid, 1'b1);
    check("lu_add_dst",   bus.dst_reg,   5'd6);
    bus.in_valid = 0;
    step();
    check("drain_valid", bus.out_valid, 1'b0);

    // Flush with a pending instruction and a concurrent write-back.
    bus.in_valid = 1;
    bus.ins = {6'h0c, 5'd0, 5'd7, 16'h00FF};
    step();
    bus.flush = 1; bus.ins = {6'h0d, 5'd0, 5'd10, 16'h1111};
    bus.wb_en = 1; bus.wb_reg = 8; bus.wb_data = 32'hBEEF;
    #1;
    check("flush_in_ready", bus.in_ready, 1'b0);
    step();
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_dst",   bus.dst_reg,   5'd7);
    check("flush_imm",   bus.imm,       32'h0000_00FF);
    check("flush_wb",    bus.dbg_reg,   32'hBEEF);
    bus.flush = 0; bus.wb_en = 0;

    // Reset asserted mid-stream with a valid result held.
    bus.ins = {6'h00, 5'd8, 5'd8, 5'd1, 5'd0, 6'h20};
    step();
    check("pre_rst_a",     bus.data_a,    32'hBEEF);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    #1 rst_n = 0;
    #1;
    check("midrst_valid",    bus.out_valid, 1'b0);
    check("midrst_dbg",      bus.dbg_reg,   32'h0);
    check("midrst_data_a",   bus.data_a,    32'h0);
    check("midrst_in_ready", bus.in_ready,  1'b0);
    #1 rst_n = 1;
    bus.in_valid = 0;

    // Randomized traffic, occasionally interrupted by a reset pulse.
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 0;
        #1;
        check("rnd_rst_valid", bus.out_valid, 1'b0);
        check("rnd_rst_dbg",   bus.dbg_reg,   32'h0);
        #1 rst_n = 1;
      end
      randomize_inputs();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
